// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the async FIFO.
// Functions work on a wide vector so any pointer width up to FN_W bits can use them.
package fifo_pkg;

   localparam int ADDR_SIZE_DEF = 3;
   localparam int PTR_W         = ADDR_SIZE_DEF + 1;
   localparam int FN_W          = 16;

   function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
      logic [FN_W-1:0] b;
      b[FN_W-1] = g[FN_W-1];
      for (int i = FN_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Producer/memory-facing bundle of the write-side controller.
// slave = the controller, master = the producer/read-domain side driving it.
interface fifo_wr_ctrl_if
   import fifo_pkg::*;
   #(parameter int ADDR_SIZE = ADDR_SIZE_DEF);

   logic                 W_INC;
   logic                 OVF_CLR;
   logic [ADDR_SIZE:0]   R_PTR;
   logic [ADDR_SIZE-1:0] W_ADDR;
   logic                 W_CLK_EN;
   logic [ADDR_SIZE:0]   W_PTR;
   logic                 FULL;
   logic                 ALMOST_FULL;
   logic [ADDR_SIZE:0]   WR_LEVEL;
   logic                 OVERFLOW;

   modport master (
      output W_INC, OVF_CLR, R_PTR,
      input  W_ADDR, W_CLK_EN, W_PTR, FULL, ALMOST_FULL, WR_LEVEL, OVERFLOW
   );

   modport slave (
      input  W_INC, OVF_CLR, R_PTR,
      output W_ADDR, W_CLK_EN, W_PTR, FULL, ALMOST_FULL, WR_LEVEL, OVERFLOW
   );

endinterface

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchroniser for a Gray pointer crossing clock domains; 2-cycle latency.
// Shared by the read- and write-side controllers.
module fifo_ptr_sync #(
   parameter int W = fifo_pkg::PTR_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO: write pointers, memory write strobe and
// full/almost-full/level/overflow status. Flags update on the same edge as the write.
module fifo_wr_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_SIZE = ADDR_SIZE_DEF,
   parameter int AF_THRESH = 6
) (
   input  logic           W_CLK,
   input  logic           W_RST,
   fifo_wr_ctrl_if.slave  wif
);

   localparam int PW = ADDR_SIZE + 1;
   // Full when the write pointer is one lap ahead: top two Gray bits inverted.
   localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

   logic [PW-1:0] wbin_q, wbin_d;
   logic [PW-1:0] wgray_q, wgray_d;
   logic          full_q, full_d;
   logic          af_q, af_d;
   logic [PW-1:0] level_q, level_d;
   logic          ovf_q, ovf_d;
   logic [PW-1:0] rq2;
   logic [PW-1:0] rbin_sync;
   logic          w_clk_en;

   fifo_ptr_sync #(.W(PW)) u_rptr_sync (
      .clk (W_CLK),
      .rst (W_RST),
      .d   (wif.R_PTR),
      .q   (rq2)
   );

   always_comb begin
      w_clk_en  = wif.W_INC & ~full_q;
      wbin_d    = wbin_q + PW'(w_clk_en);
      wgray_d   = PW'(bin2gray(FN_W'(wbin_d)));
      rbin_sync = PW'(gray2bin(FN_W'(rq2)));
      full_d    = (wgray_d == (rq2 ^ FULL_MASK));
      level_d   = wbin_d - rbin_sync;
      af_d      = (level_d >= PW'(AF_THRESH));
      ovf_d     = ovf_q;
      if (wif.W_INC && full_q) begin
         ovf_d = 1'b1;
      end else if (wif.OVF_CLR) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge W_CLK) begin
      if (W_RST) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         full_q  <= full_d;
         af_q    <= af_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
      end
   end

   assign wif.W_ADDR      = wbin_q[ADDR_SIZE-1:0];
   assign wif.W_CLK_EN    = w_clk_en;
   assign wif.W_PTR       = wgray_q;
   assign wif.FULL        = full_q;
   assign wif.ALMOST_FULL = af_q;
   assign wif.WR_LEVEL    = level_q;
   assign wif.OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: occupancy model built on write/read counts, with a queue of
// expected memory write addresses popped whenever the DUT strobes W_CLK_EN.
module tb_fifo_wr_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_wr_ctrl_if #(.ADDR_SIZE(3)) bus ();

   fifo_wr_ctrl #(.ADDR_SIZE(3), .AF_THRESH(6)) dut (
      .W_CLK (clk),
      .W_RST (rst),
      .wif   (bus)
   );

   int  n_tests = 0;
   int  n_fail  = 0;
   int  wr_cnt, rd_cnt, r1, r2, m_level;
   bit  m_full, m_af, m_ovf, saw_full;
   int  exp_addr_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] to_gray(input int n);
      logic [3:0] b;
      b = n[3:0];
      return b ^ (b >> 1);
   endfunction

   // One clock cycle: drive, check the write strobe, clock, update model, check flags.
   task automatic step(input bit r, input bit inc, input bit clr);
      bit accept;
      bit ovf_set;
      accept      = 1'b0;
      rst         = r;
      bus.W_INC   = inc;
      bus.OVF_CLR = clr;
      bus.R_PTR   = to_gray(rd_cnt);
      #1;
      if (!r) begin
         accept = inc && !m_full;
         chk("w_clk_en", 32'(bus.W_CLK_EN), 32'(accept));
         if (accept) exp_addr_q.push_back(wr_cnt % 8);
         if (bus.W_CLK_EN) begin
            if (exp_addr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else chk("mem_write_addr", 32'(bus.W_ADDR), 32'(exp_addr_q.pop_front()));
         end
      end
      @(posedge clk);
      #1;
      if (r) begin
         wr_cnt = 0; r1 = 0; r2 = 0; m_level = 0;
         m_full = 0; m_af = 0; m_ovf = 0;
      end else begin
         ovf_set = inc && m_full;
         if (accept) wr_cnt++;
         m_level = (wr_cnt - r2) & 15;
         m_full  = (m_level == 8);
         m_af    = (m_level >= 6);
         if (ovf_set) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
         r2 = r1;
         r1 = rd_cnt;
      end
      chk("w_addr",      32'(bus.W_ADDR),      32'(wr_cnt % 8));
      chk("w_ptr",       32'(bus.W_PTR),       32'(to_gray(wr_cnt)));
      chk("full",        32'(bus.FULL),        32'(m_full));
      chk("almost_full", 32'(bus.ALMOST_FULL), 32'(m_af));
      chk("wr_level",    32'(bus.WR_LEVEL),    32'(m_level));
      chk("overflow",    32'(bus.OVERFLOW),    32'(m_ovf));
      if (bus.FULL) saw_full = 1'b1;
   endtask

   initial begin
      wr_cnt = 0; rd_cnt = 0; r1 = 0; r2 = 0; m_level = 0;
      m_full = 0; m_af = 0; m_ovf = 0; saw_full = 0;
      rst = 1'b1; bus.W_INC = 1'b0; bus.OVF_CLR = 1'b0; bus.R_PTR = '0;
      #2;

      // Reset held with W_INC=1, then the first write.
      repeat (3) step(1, 1, 0);
      chk("rst_w_ptr", 32'(bus.W_PTR), 32'd0);
      chk("rst_full", 32'(bus.FULL), 32'd0);
      step(0, 1, 0);
      chk("first_w_ptr", 32'(bus.W_PTR), 32'b0001);

      // Fill to full with R_PTR=0.
      for (int i = 2; i <= 8; i++) begin
         step(0, 1, 0);
         if (i == 5) chk("af_after_5", 32'(bus.ALMOST_FULL), 32'd0);
         if (i == 6) chk("af_after_6", 32'(bus.ALMOST_FULL), 32'd1);
      end
      chk("full_after_8", 32'(bus.FULL), 32'd1);
      chk("level_after_8", 32'(bus.WR_LEVEL), 32'd8);
      chk("w_ptr_after_8", 32'(bus.W_PTR), 32'b1100);

      // Overflow set/clear, set wins over clear.
      step(0, 1, 0);
      chk("ovf_set", 32'(bus.OVERFLOW), 32'd1);
      chk("ptr_hold_full", 32'(bus.W_PTR), 32'b1100);
      step(0, 0, 1);
      chk("ovf_clr", 32'(bus.OVERFLOW), 32'd0);
      step(0, 1, 1);
      chk("ovf_set_wins", 32'(bus.OVERFLOW), 32'd1);
      step(0, 0, 1);

      // Read pointer advance reaches FULL three edges later.
      rd_cnt = 1;
      step(0, 0, 0);
      chk("full_edge1", 32'(bus.FULL), 32'd1);
      step(0, 0, 0);
      chk("full_edge2", 32'(bus.FULL), 32'd1);
      step(0, 0, 0);
      chk("full_edge3", 32'(bus.FULL), 32'd0);
      chk("level_edge3", 32'(bus.WR_LEVEL), 32'd7);
      chk("addr_before_refill", 32'(bus.W_ADDR), 32'd0);
      step(0, 1, 0);
      chk("refill_full", 32'(bus.FULL), 32'd1);

      // 16 writes with the reader one step behind: full lap, no FULL.
      rd_cnt = 0;
      step(1, 0, 0);
      saw_full = 0;
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 0);
         rd_cnt = wr_cnt;
      end
      repeat (3) step(0, 0, 0);
      chk("wrap_w_ptr", 32'(bus.W_PTR), 32'd0);
      chk("wrap_w_addr", 32'(bus.W_ADDR), 32'd0);
      chk("wrap_never_full", 32'(saw_full), 32'd0);
      chk("wrap_level", 32'(bus.WR_LEVEL), 32'd0);

      // Reset mid-burst.
      rd_cnt = 0;
      step(1, 0, 0);
      repeat (5) step(0, 1, 0);
      chk("level_before_rst", 32'(bus.WR_LEVEL), 32'd5);
      step(1, 1, 0);
      chk("mid_rst_level", 32'(bus.WR_LEVEL), 32'd0);
      chk("mid_rst_w_ptr", 32'(bus.W_PTR), 32'd0);
      chk("mid_rst_w_addr", 32'(bus.W_ADDR), 32'd0);
      step(0, 0, 0);
      chk("post_rst_level", 32'(bus.WR_LEVEL), 32'd0);

      chk("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
